multiplexor_arbitrado_nx1: RTL and testbench

- Parametrised, registered N:1 data multiplexor for the ciscud datapath; the next generation of the 16-bit 2:1 selector.
- Each input channel has a valid/ready handshake.
- Two modes: explicit select by Selector, or round-robin arbitration.
- One output register stage; serves the shared bus paths: register file write-back and memory data merge.

---
 rtl/multiplexor_arbitrado_nx1.sv | 246 ++++++++++++++++++++++++
 tb/tb_multiplexor_arbitrado_nx1.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplexor_arbitrado_nx1.sv
`default_nettype none
// ============================================================================
// Module      : multiplexor_arbitrado_nx1
// Description : Registered N:1 data multiplexor with per-channel valid/ready
//               handshakes. Channel choice is either explicit (Selector,
//               MODO=0) or round-robin (MODO=1). A single output register
//               stage carries data, source channel index and valid flag.
//               The register is replaced in the same cycle it is drained,
//               so sustained throughput is one beat per clock.
//
// Parameters  : ANCHO     - data width per channel
//               CANALES   - number of input channels (2..16)
//               ANCHO_SEL - width of Selector/SalidaCanal, clog2(CANALES)
//               MODO      - 0: Selector-driven, 1: round-robin
//
// Ports       : Reloj          in   clock, rising edge
//               Reset          in   asynchronous active-high reset
//               Entrada        in   packed channel data, channel i at
//                                   [i*ANCHO +: ANCHO]
//               EntradaValida  in   per-channel valid
//               EntradaListo   out  per-channel accept (combinational)
//               Selector       in   channel select (MODO=0 only)
//               Salida         out  registered output data
//               SalidaValida   out  output register holds data
//               SalidaCanal    out  channel that supplied Salida
//               SalidaListo    in   downstream accept
//
// Optional    : MULTIPLEXOR_PAQUETES_EN
//               Adds EntradaUltimo (in, per channel) and SalidaUltimo (out).
//               A beat without Ultimo locks the grant to its channel until
//               that channel delivers a beat with Ultimo set.
//
// Revision    : 1.0 - initial release
// ============================================================================
module multiplexor_arbitrado_nx1 #(
  parameter int ANCHO     = 16,
  parameter int CANALES   = 4,
  parameter int ANCHO_SEL = 2,
  parameter int MODO      = 0
) (
  input  logic                     Reloj,
  input  logic                     Reset,
  input  logic [CANALES*ANCHO-1:0] Entrada,
  input  logic [CANALES-1:0]       EntradaValida,
  output logic [CANALES-1:0]       EntradaListo,
  input  logic [ANCHO_SEL-1:0]     Selector,
  output logic [ANCHO-1:0]         Salida,
  output logic                     SalidaValida,
  output logic [ANCHO_SEL-1:0]     SalidaCanal,
  input  logic                     SalidaListo
`ifdef MULTIPLEXOR_PAQUETES_EN
  ,
  input  logic [CANALES-1:0]       EntradaUltimo,
  output logic                     SalidaUltimo
`endif
);

  // --------------------------------------------------------------------------
  // Output register occupancy
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    VACIO = 1'b0,
    LLENO = 1'b1
  } estado_t;

  estado_t              r_estado;
  estado_t              w_estado_sig;

  logic [ANCHO-1:0]     r_salida;
  logic [ANCHO_SEL-1:0] r_canal;

  logic                 w_carga;      // register may accept a new beat
  logic                 w_xfer_in;    // a channel is transferring this cycle
  logic                 w_xfer_out;   // downstream consumes the register
  logic [CANALES-1:0]   w_grant_arb;  // grant from the selector/arbiter
  logic [CANALES-1:0]   w_grant;      // grant after packet locking
  logic [ANCHO_SEL-1:0] w_idx;        // index of the granted channel
  logic [ANCHO-1:0]     w_dato;       // data of the granted channel

  // The register can load when empty, or when its current content leaves
  // in this same cycle (replacement without a bubble).
  assign w_carga    = (r_estado == VACIO) | SalidaListo;
  assign EntradaListo = w_grant & {CANALES{w_carga & ~Reset}};
  // A grant is only ever raised for a valid channel, so any ready bit
  // already implies a completed input handshake.
  assign w_xfer_in  = |EntradaListo;
  assign w_xfer_out = (r_estado == LLENO) & SalidaListo;

  // --------------------------------------------------------------------------
  // Packet locking (optional)
  // --------------------------------------------------------------------------
`ifdef MULTIPLEXOR_PAQUETES_EN
  logic               r_bloqueo;
  logic               r_ultimo;
  logic [CANALES-1:0] w_grant_bloq;
  logic               w_ultimo_in;

  // While locked, the locked channel is the one recorded in r_canal: the
  // lock is only ever set by a transfer that also loads r_canal, and
  // r_canal cannot change until another transfer happens.
  always_comb begin
    w_grant_bloq = '0;
    for (int i = 0; i < CANALES; i++) begin
      w_grant_bloq[i] = EntradaValida[i] & (r_canal == ANCHO_SEL'(i));
    end
  end

  assign w_grant     = r_bloqueo ? w_grant_bloq : w_grant_arb;
  assign w_ultimo_in = |(EntradaListo & EntradaUltimo);

  always_ff @(posedge Reloj or posedge Reset) begin
    if (Reset) begin
      r_bloqueo <= 1'b0;
      r_ultimo  <= 1'b0;
    end else if (w_xfer_in) begin
      r_bloqueo <= ~w_ultimo_in;
      r_ultimo  <= w_ultimo_in;
    end
  end

  assign SalidaUltimo = r_ultimo;
`else
  assign w_grant = w_grant_arb;
`endif

  // --------------------------------------------------------------------------
  // Channel selection
  // --------------------------------------------------------------------------
  generate
    if (MODO == 1) begin : g_rr
      logic [ANCHO_SEL-1:0] r_ptr;
      logic [CANALES-1:0]   w_alto;       // valid channels at or above r_ptr
      logic [CANALES-1:0]   w_pri_alto;   // lowest of those
      logic [CANALES-1:0]   w_pri_todo;   // lowest valid channel overall
      logic                 w_avanza;

      always_comb begin
        w_alto = '0;
        for (int i = 0; i < CANALES; i++) begin
          w_alto[i] = EntradaValida[i] & (i >= int'(r_ptr));
        end
      end

      // x & -x isolates the lowest set bit. Searching upward from the
      // pointer with wrap-around is the lowest requester above the pointer,
      // or failing that the lowest requester overall.
      assign w_pri_alto  = w_alto & (~w_alto + CANALES'(1));
      assign w_pri_todo  = EntradaValida & (~EntradaValida + CANALES'(1));
      assign w_grant_arb = (|w_alto) ? w_pri_alto : w_pri_todo;

`ifdef MULTIPLEXOR_PAQUETES_EN
      // Within a packet the pointer stays put; it moves past the channel
      // only when the packet closes.
      assign w_avanza = w_xfer_in & w_ultimo_in;
`else
      assign w_avanza = w_xfer_in;
`endif

      // Explicit wrap so that non power-of-two channel counts never point
      // at a channel that does not exist.
      always_ff @(posedge Reloj or posedge Reset) begin
        if (Reset) begin
          r_ptr <= '0;
        end else if (w_avanza) begin
          if (w_idx == ANCHO_SEL'(CANALES - 1)) begin
            r_ptr <= '0;
          end else begin
            r_ptr <= w_idx + ANCHO_SEL'(1);
          end
        end
      end
    end else begin : g_sel
      // Selector values at or beyond CANALES match no channel and
      // therefore produce no grant.
      always_comb begin
        w_grant_arb = '0;
        for (int i = 0; i < CANALES; i++) begin
          w_grant_arb[i] = EntradaValida[i] & (Selector == ANCHO_SEL'(i));
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // One-hot grant to index and data
  // --------------------------------------------------------------------------
  always_comb begin
    w_idx  = '0;
    w_dato = '0;
    for (int i = 0; i < CANALES; i++) begin
      if (w_grant[i]) begin
        w_idx  = ANCHO_SEL'(i);
        w_dato = Entrada[i*ANCHO +: ANCHO];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Occupancy state machine
  // --------------------------------------------------------------------------
  always_ff @(posedge Reloj or posedge Reset) begin
    if (Reset) begin
      r_estado <= VACIO;
    end else begin
      r_estado <= w_estado_sig;
    end
  end

  always_comb begin
    w_estado_sig = r_estado;
    unique case (r_estado)
      VACIO: begin
        if (w_xfer_in) begin
          w_estado_sig = LLENO;
        end
      end
      LLENO: begin
        if (w_xfer_in) begin
          w_estado_sig = LLENO;
        end else if (w_xfer_out) begin
          w_estado_sig = VACIO;
        end
      end
      default: w_estado_sig = VACIO;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output data register; content holds when drained without a refill
  // --------------------------------------------------------------------------
  always_ff @(posedge Reloj or posedge Reset) begin
    if (Reset) begin
      r_salida <= '0;
      r_canal  <= '0;
    end else if (w_xfer_in) begin
      r_salida <= w_dato;
      r_canal  <= w_idx;
    end
  end

  assign Salida       = r_salida;
  assign SalidaCanal  = r_canal;
  assign SalidaValida = (r_estado == LLENO);

endmodule
`default_nettype wire

// File: tb/tb_multiplexor_arbitrado_nx1.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiplexor_arbitrado_nx1
// Description : Self-checking bench for multiplexor_arbitrado_nx1. Four
//               instances: round-robin x4, selector x4, round-robin x3,
//               selector x3. A behavioural model runs alongside every
//               instance each cycle; directed tables and sequences add
//               hand-computed expectations. Packet locking is exercised
//               when MULTIPLEXOR_PAQUETES_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multiplexor_arbitrado_nx1;

  localparam int ND = 4;
`ifdef MULTIPLEXOR_PAQUETES_EN
  localparam bit PKT = 1'b1;
`else
  localparam bit PKT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] ent  [ND];
  logic [3:0]  ev   [ND];
  logic [1:0]  sel  [ND];
  logic        sl   [ND];
  logic [3:0]  ult  [ND];
  logic [3:0]  o_l  [ND];
  logic [15:0] o_d  [ND];
  logic        o_v  [ND];
  logic [1:0]  o_c  [ND];
  logic        o_u  [ND];
  logic [2:0]  l_c3a, l_c3b;

  always #5 clk = ~clk;

  assign o_l[2] = {1'b0, l_c3a};
  assign o_l[3] = {1'b0, l_c3b};
`ifndef MULTIPLEXOR_PAQUETES_EN
  assign o_u[0] = 1'b0;
  assign o_u[1] = 1'b0;
  assign o_u[2] = 1'b0;
  assign o_u[3] = 1'b0;
`endif

  multiplexor_arbitrado_nx1 #(.ANCHO(16), .CANALES(4), .ANCHO_SEL(2), .MODO(1)) u_rr4 (
    .Reloj(clk), .Reset(rst), .Entrada(ent[0]), .EntradaValida(ev[0]),
    .EntradaListo(o_l[0]), .Selector(sel[0]), .Salida(o_d[0]),
    .SalidaValida(o_v[0]), .SalidaCanal(o_c[0]), .SalidaListo(sl[0])
`ifdef MULTIPLEXOR_PAQUETES_EN
    , .EntradaUltimo(ult[0]), .SalidaUltimo(o_u[0])
`endif
  );

  multiplexor_arbitrado_nx1 #(.ANCHO(16), .CANALES(4), .ANCHO_SEL(2), .MODO(0)) u_sel4 (
    .Reloj(clk), .Reset(rst), .Entrada(ent[1]), .EntradaValida(ev[1]),
    .EntradaListo(o_l[1]), .Selector(sel[1]), .Salida(o_d[1]),
    .SalidaValida(o_v[1]), .SalidaCanal(o_c[1]), .SalidaListo(sl[1])
`ifdef MULTIPLEXOR_PAQUETES_EN
    , .EntradaUltimo(ult[1]), .SalidaUltimo(o_u[1])
`endif
  );

  multiplexor_arbitrado_nx1 #(.ANCHO(16), .CANALES(3), .ANCHO_SEL(2), .MODO(1)) u_rr3 (
    .Reloj(clk), .Reset(rst), .Entrada(ent[2][47:0]), .EntradaValida(ev[2][2:0]),
    .EntradaListo(l_c3a), .Selector(sel[2]), .Salida(o_d[2]),
    .SalidaValida(o_v[2]), .SalidaCanal(o_c[2]), .SalidaListo(sl[2])
`ifdef MULTIPLEXOR_PAQUETES_EN
    , .EntradaUltimo(ult[2][2:0]), .SalidaUltimo(o_u[2])
`endif
  );

  multiplexor_arbitrado_nx1 #(.ANCHO(16), .CANALES(3), .ANCHO_SEL(2), .MODO(0)) u_sel3 (
    .Reloj(clk), .Reset(rst), .Entrada(ent[3][47:0]), .EntradaValida(ev[3][2:0]),
    .EntradaListo(l_c3b), .Selector(sel[3]), .Salida(o_d[3]),
    .SalidaValida(o_v[3]), .SalidaCanal(o_c[3]), .SalidaListo(sl[3])
`ifdef MULTIPLEXOR_PAQUETES_EN
    , .EntradaUltimo(ult[3][2:0]), .SalidaUltimo(o_u[3])
`endif
  );

  // ------------------------------------------------------------------------
  // Reference model state (per instance)
  // ------------------------------------------------------------------------
  bit          m_v    [ND];
  logic [15:0] m_d    [ND];
  int          m_ch   [ND];
  int          m_ptr  [ND];
  bit          m_lock [ND];
  int          m_lch  [ND];
  bit          m_last [ND];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int modo_de(int d);
    return (d == 0 || d == 2) ? 1 : 0;
  endfunction

  function automatic int can_de(int d);
    return (d < 2) ? 4 : 3;
  endfunction

  function automatic int exp_grant(int d);
    int c;
    int ch;
    c = can_de(d);
    if (m_lock[d]) return ev[d][m_lch[d]] ? m_lch[d] : -1;
    if (modo_de(d) == 0) begin
      if (int'(sel[d]) < c && ev[d][sel[d]]) return int'(sel[d]);
      return -1;
    end
    for (int k = 0; k < c; k++) begin
      ch = (m_ptr[d] + k) % c;
      if (ev[d][ch]) return ch;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_listo(int d);
    int g;
    g = exp_grant(d);
    if (rst || g < 0 || !(!m_v[d] || sl[d])) return 4'b0000;
    return 4'(1 << g);
  endfunction

  task automatic model_reset(int d);
    m_v[d] = 0; m_d[d] = '0; m_ch[d] = 0; m_ptr[d] = 0;
    m_lock[d] = 0; m_lch[d] = 0; m_last[d] = 0;
  endtask

  task automatic model_edge(int d);
    int g;
    bit carga;
    if (rst) begin
      model_reset(d);
    end else begin
      g     = exp_grant(d);
      carga = !m_v[d] || sl[d];
      if (g >= 0 && carga) begin
        m_v[d]    = 1;
        m_d[d]    = ent[d][g*16 +: 16];
        m_ch[d]   = g;
        m_last[d] = PKT ? ult[d][g] : 1'b0;
        if (PKT) begin
          m_lock[d] = !ult[d][g];
          m_lch[d]  = g;
        end
        if (modo_de(d) == 1 && (!PKT || ult[d][g])) m_ptr[d] = (g + 1) % can_de(d);
      end else if (m_v[d] && sl[d]) begin
        m_v[d] = 0;
      end
    end
  endtask

  task automatic chk(string nm, int d, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d actual=%h expected=%h t=%0t", nm, d, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    for (int d = 0; d < ND; d++) begin
      chk("SalidaValida", d, 16'(o_v[d]), 16'(m_v[d]));
      chk("Salida", d, o_d[d], m_d[d]);
      chk("SalidaCanal", d, 16'(o_c[d]), 16'(m_ch[d]));
      if (PKT) chk("SalidaUltimo", d, 16'(o_u[d]), 16'(m_last[d]));
    end
  endtask

  // One clock: ready check before the edge, model step, output check after.
  task automatic ciclo();
    #1;
    for (int d = 0; d < ND; d++) chk("EntradaListo", d, 16'(o_l[d]), 16'(exp_listo(d)));
    @(posedge clk);
    for (int d = 0; d < ND; d++) model_edge(d);
    #1;
    check_outputs();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) model_reset(d);
    check_outputs();
    ciclo();
    rst = 1'b0;
  endtask

  task automatic idle_all();
    for (int d = 0; d < ND; d++) begin
      ev[d] = 4'b0000; sel[d] = 2'd0; sl[d] = 1'b1; ult[d] = 4'b1111;
    end
  endtask

  typedef struct {
    logic [3:0]  ev;
    logic        sl;
    logic [3:0]  listo;
    logic        v;
    logic [15:0] d;
    logic [1:0]  ch;
  } fila_t;

  fila_t tabla [13];

  initial begin
    // Round-robin x4, all data 16'h1000+i, starting from reset (pointer 0).
    tabla[0]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 16'h1000, 2'd0};
    tabla[1]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 16'h1001, 2'd1};
    tabla[2]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 16'h1002, 2'd2};
    tabla[3]  = '{4'hF, 1'b1, 4'b1000, 1'b1, 16'h1003, 2'd3};
    tabla[4]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 16'h1000, 2'd0};
    tabla[5]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 16'h1000, 2'd0};
    tabla[6]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 16'h1000, 2'd0};
    tabla[7]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 16'h1000, 2'd0};
    tabla[8]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 16'h1000, 2'd0};
    tabla[9]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 16'h1000, 2'd0};
    tabla[10] = '{4'hF, 1'b1, 4'b0010, 1'b1, 16'h1001, 2'd1};
    tabla[11] = '{4'h0, 1'b1, 4'b0000, 1'b0, 16'h1001, 2'd1};
    tabla[12] = '{4'h0, 1'b0, 4'b0000, 1'b0, 16'h1001, 2'd1};

    for (int d = 0; d < ND; d++) ent[d] = '0;
    idle_all();
    ent[0] = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    ev[0]  = 4'hF;

    // Reset state, with valid requests present.
    #1 rst = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) model_reset(d);
    chk("rst_Salida", 0, o_d[0], 16'h0000);
    chk("rst_SalidaValida", 0, 16'(o_v[0]), 16'h0000);
    chk("rst_SalidaCanal", 0, 16'(o_c[0]), 16'h0000);
    chk("rst_EntradaListo", 0, 16'(o_l[0]), 16'h0000);
    ciclo();
    rst = 1'b0;

    // Table-driven round-robin / back-pressure sequence.
    for (int r = 0; r < 13; r++) begin
      ev[0] = tabla[r].ev;
      sl[0] = tabla[r].sl;
      #1;
      chk("tab_EntradaListo", r, 16'(o_l[0]), 16'(tabla[r].listo));
      ciclo();
      chk("tab_SalidaValida", r, 16'(o_v[0]), 16'(tabla[r].v));
      chk("tab_Salida", r, o_d[0], tabla[r].d);
      chk("tab_SalidaCanal", r, 16'(o_c[0]), 16'(tabla[r].ch));
    end

    // Load 16'h1234 from channel 2 (pointer becomes 3), stall, then reset.
    ent[0][47:32] = 16'h1234;
    ev[0] = 4'b0100; sl[0] = 1'b0;
    ciclo();
    ev[0] = 4'hF;
    ciclo();
    chk("hold_Salida", 0, o_d[0], 16'h1234);
    chk("hold_SalidaCanal", 0, 16'(o_c[0]), 16'h0002);
    #2 rst = 1'b1;
    #1;
    chk("async_SalidaValida", 0, 16'(o_v[0]), 16'h0000);
    chk("async_Salida", 0, o_d[0], 16'h0000);
    chk("async_SalidaCanal", 0, 16'(o_c[0]), 16'h0000);
    chk("async_EntradaListo", 0, 16'(o_l[0]), 16'h0000);
    for (int d = 0; d < ND; d++) model_reset(d);
    ciclo();
    rst = 1'b0;
    sl[0] = 1'b1;
    #1;
    chk("post_rst_grant", 0, 16'(o_l[0]), 16'h0001);
    ciclo();
    ent[0][47:32] = 16'h1002;
    idle_all();
    ciclo();

    // Selector mode x4, and out-of-range Selector on the x3 instance.
    ent[1] = {16'h3333, 16'hBEEF, 16'h1111, 16'h0A0A};
    ent[3] = {16'h0000, 16'h2222, 16'h1111, 16'h0000};
    ev[1] = 4'b0101; sel[1] = 2'd2;
    #1;
    chk("sel2_EntradaListo", 1, 16'(o_l[1]), 16'h0004);
    ciclo();
    chk("sel2_Salida", 1, o_d[1], 16'hBEEF);
    chk("sel2_SalidaCanal", 1, 16'(o_c[1]), 16'h0002);
    sel[1] = 2'd0;
    #1;
    chk("sel0_EntradaListo", 1, 16'(o_l[1]), 16'h0001);
    ciclo();
    chk("sel0_Salida", 1, o_d[1], 16'h0A0A);
    sel[1] = 2'd2; ev[1] = 4'b0001;
    sel[3] = 2'd3; ev[3] = 4'b0111;
    #1;
    chk("sel_invalid_EntradaListo", 1, 16'(o_l[1]), 16'h0000);
    chk("sel_range_EntradaListo", 3, 16'(o_l[3]), 16'h0000);
    ciclo();
    chk("sel_drain_SalidaValida", 1, 16'(o_v[1]), 16'h0000);
    idle_all();

    // Round-robin x3: order 0,1,2,0.
    ent[2] = {16'h0000, 16'hC002, 16'hC001, 16'hC000};
    ev[2] = 4'b0111;
    for (int k = 0; k < 4; k++) begin
      ciclo();
      chk("rr3_SalidaCanal", 2, 16'(o_c[2]), 16'(k % 3));
    end
    idle_all();
    ciclo();

`ifdef MULTIPLEXOR_PAQUETES_EN
    // Channel 1 sends a 3-beat packet while channel 2 keeps requesting.
    pulse_reset();
    idle_all();
    ev[0] = 4'b0110; ult[0] = 4'b0000;
    ciclo();
    chk("pkt_b1_canal", 0, 16'(o_c[0]), 16'h0001);
    chk("pkt_b1_ultimo", 0, 16'(o_u[0]), 16'h0000);
    ev[0] = 4'b0100;
    #1;
    chk("pkt_lock_idle", 0, 16'(o_l[0]), 16'h0000);
    ciclo();
    ev[0] = 4'b0110;
    ciclo();
    chk("pkt_b2_canal", 0, 16'(o_c[0]), 16'h0001);
    chk("pkt_b2_ultimo", 0, 16'(o_u[0]), 16'h0000);
    ult[0] = 4'b0010;
    ciclo();
    chk("pkt_b3_canal", 0, 16'(o_c[0]), 16'h0001);
    chk("pkt_b3_ultimo", 0, 16'(o_u[0]), 16'h0001);
    ult[0] = 4'b0100;
    ciclo();
    chk("pkt_next_canal", 0, 16'(o_c[0]), 16'h0002);
    idle_all();
    ciclo();
`endif

    // Randomised traffic against the model on all instances.
    for (int n = 0; n < 3000; n++) begin
      for (int d = 0; d < ND; d++) begin
        ent[d] = {$urandom, $urandom};
        ev[d]  = 4'($urandom) & ((can_de(d) == 4) ? 4'b1111 : 4'b0111);
        sel[d] = 2'($urandom);
        sl[d]  = ($urandom % 4) != 0;
        ult[d] = 4'($urandom) | 4'($urandom);
      end
      if ($urandom % 150 == 0) pulse_reset();
      else ciclo();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
